// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: redirect priority encoding and default vectors.
package cpu_pkg;

    typedef enum logic [2:0] {
        PRI_NONE = 3'd0,
        PRI_JMP  = 3'd1,
        PRI_BR   = 3'd2,
        PRI_ERET = 3'd3,
        PRI_EXC  = 3'd4
    } redirect_pri_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'hBFC0_0380;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: picks the highest-priority live redirect
// (exc > eret > branch > jump) and muxes its target.
module pc_redirect_arb
    import cpu_pkg::*;
#(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR)
) (
    input  logic                  exc_en_i,
    input  logic                  eret_en_i,
    input  logic [WIDTH-1:0]      epc_i,
    input  logic                  br_taken_i,
    input  logic [WIDTH-1:0]      br_target_i,
    input  logic                  jmp_en_i,
    input  logic [WIDTH-1:0]      jmp_target_i,
    output logic                  redir_valid_o,
    output redirect_pri_e         redir_pri_o,
    output logic [WIDTH-1:0]      redir_target_o
);

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        redir_pri_o    = PRI_NONE;
        redir_target_o = '0;
        if (exc_en_i) begin
            redir_pri_o    = PRI_EXC;
            redir_target_o = EXC_VECTOR;
        end else if (eret_en_i) begin
            redir_pri_o    = PRI_ERET;
            redir_target_o = epc_i;
        end else if (br_taken_i) begin
            redir_pri_o    = PRI_BR;
            redir_target_o = br_target_i;
        end else if (jmp_en_i) begin
            redir_pri_o    = PRI_JMP;
            redir_target_o = jmp_target_i;
        end
    end

    assign redir_valid_o = (redir_pri_o != PRI_NONE);

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: PC register, PC+INC, redirect arbitration and stall-time
// redirect buffering. Define PC_ALIGN_CHECK_EN to flag misaligned PCs instead of masking.
module pc_gen_unit
    import cpu_pkg::*;
#(
    parameter int                 WIDTH        = 32,
    parameter int                 INC          = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_ready,
    input  logic                  exc_en,
    input  logic                  eret_en,
    input  logic [WIDTH-1:0]      epc,
    input  logic                  br_taken,
    input  logic [WIDTH-1:0]      br_target,
    input  logic                  jmp_en,
    input  logic [WIDTH-1:0]      jmp_target,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      pc_plus,
    output logic                  pc_valid,
    output logic                  redirect_pending,
    output logic                  fetch_misalign
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q;
    logic             pend_q, pend_d;
    redirect_pri_e    pend_pri_q, pend_pri_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;

    logic             redir_valid;
    redirect_pri_e    redir_pri;
    logic [WIDTH-1:0] redir_target;
    logic [WIDTH-1:0] load_target;
    logic             accept;

    pc_redirect_arb #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .exc_en_i       (exc_en),
        .eret_en_i      (eret_en),
        .epc_i          (epc),
        .br_taken_i     (br_taken),
        .br_target_i    (br_target),
        .jmp_en_i       (jmp_en),
        .jmp_target_i   (jmp_target),
        .redir_valid_o  (redir_valid),
        .redir_pri_o    (redir_pri),
        .redir_target_o (redir_target)
    );

`ifdef PC_ALIGN_CHECK_EN
    assign load_target = redir_target;
`else
    assign load_target = redir_target & ~WIDTH'(3);
`endif

    assign accept  = pc_valid_q && if_ready;
    assign pc_plus = pc_q + WIDTH'(INC);

    always_comb begin
        pc_d          = pc_q;
        pend_d        = pend_q;
        pend_pri_d    = pend_pri_q;
        pend_target_d = pend_target_q;
        if (accept) begin
            if (redir_valid)  pc_d = load_target;
            else if (pend_q)  pc_d = pend_target_q;
            else              pc_d = pc_plus;
            pend_d     = 1'b0;
            pend_pri_d = PRI_NONE;
        end else if (redir_valid && (redir_pri >= pend_pri_q)) begin
            // An empty buffer holds PRI_NONE, so any redirect is accepted into it.
            pend_d        = 1'b1;
            pend_pri_d    = redir_pri;
            pend_target_d = load_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            pc_valid_q    <= 1'b0;
            pend_q        <= 1'b0;
            pend_pri_q    <= PRI_NONE;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            pc_valid_q    <= 1'b1;
            pend_q        <= pend_d;
            pend_pri_q    <= pend_pri_d;
            pend_target_q <= pend_target_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      misalign_q <= 1'b0;
        else if (accept) misalign_q <= (pc_d[1:0] != 2'b00);
    end

    assign fetch_misalign = misalign_q;
`else
    assign fetch_misalign = 1'b0;
`endif

    assign pc               = pc_q;
    assign pc_valid         = pc_valid_q;
    assign redirect_pending = pend_q;

endmodule
